// File: rtl/seq_divmod.sv
// Sequential restoring unsigned divider: quotient/remainder for a runtime divisor.
// Latency WIDTH edges (1 for divide-by-zero); a result is held in DONE until out_ready.
module seq_divmod #(
  parameter int WIDTH  = 8,
  parameter int DWIDTH = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  dividend,
  input  logic [DWIDTH-1:0] divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  quotient,
  output logic [DWIDTH-1:0] remainder,
  output logic              div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [WIDTH-1:0]    qreg_q;
  logic [DWIDTH:0]     part_q;
  logic [DWIDTH-1:0]   div_q;
  logic [CW-1:0]       cnt_q;
  logic [WIDTH-1:0]    quot_q;
  logic [DWIDTH-1:0]   rem_q;
  logic                dz_q;
  logic                in_ready_q;
  logic                out_valid_q;

  logic [DWIDTH:0]     trial_d;
  logic                ge_d;
  logic [DWIDTH:0]     part_d;
  logic [WIDTH-1:0]    qreg_d;

  // One restoring step; the spare partial bit keeps the trial compare from overflowing.
  always_comb begin
    trial_d = {part_q[DWIDTH-1:0], qreg_q[WIDTH-1]};
    ge_d    = part_q[DWIDTH] | (trial_d >= {1'b0, div_q});
    part_d  = ge_d ? (trial_d - {1'b0, div_q}) : trial_d;
    qreg_d  = {qreg_q[WIDTH-2:0], ge_d};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      qreg_q      <= '0;
      part_q      <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      dz_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            qreg_q     <= dividend;
            div_q      <= divisor;
            part_q     <= '0;
            cnt_q      <= CW'(WIDTH);
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          if (div_q == '0) begin
            // Zero divisor resolves in a single cycle with a saturated quotient.
            quot_q      <= '1;
            rem_q       <= qreg_q[DWIDTH-1:0];
            dz_q        <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            qreg_q <= qreg_d;
            part_q <= part_d;
            cnt_q  <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              quot_q      <= qreg_d;
              rem_q       <= part_d[DWIDTH-1:0];
              dz_q        <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_seq_divmod.sv
// Bench for seq_divmod at 8/4 and 16/8 widths, multiplexed onto one set of stimulus signals.
module tb_seq_divmod;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        resetn;
  logic        sel;
  logic        in_valid;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, div_zero_a;
  logic [7:0]  quotient_a;
  logic [3:0]  remainder_a;
  logic        in_ready_b, out_valid_b, div_zero_b;
  logic [15:0] quotient_b;
  logic [7:0]  remainder_b;

  logic        in_ready, out_valid, div_zero;
  logic [15:0] quotient;
  logic [7:0]  remainder;

  seq_divmod #(.WIDTH(8), .DWIDTH(4)) dut_a (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid & ~sel), .in_ready(in_ready_a),
    .dividend(dividend[7:0]), .divisor(divisor[3:0]),
    .out_valid(out_valid_a), .out_ready(out_ready & ~sel),
    .quotient(quotient_a), .remainder(remainder_a), .div_zero(div_zero_a)
  );

  seq_divmod #(.WIDTH(16), .DWIDTH(8)) dut_b (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid & sel), .in_ready(in_ready_b),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid_b), .out_ready(out_ready & sel),
    .quotient(quotient_b), .remainder(remainder_b), .div_zero(div_zero_b)
  );

  assign in_ready  = sel ? in_ready_b  : in_ready_a;
  assign out_valid = sel ? out_valid_b : out_valid_a;
  assign div_zero  = sel ? div_zero_b  : div_zero_a;
  assign quotient  = sel ? quotient_b  : {8'h00, quotient_a};
  assign remainder = sel ? remainder_b : {4'h0, remainder_a};

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Drive one operation, wait for acceptance and push the model result.
  task automatic send(input logic [15:0] a_in, input logic [7:0] b_in);
    exp_t        e;
    logic [15:0] a;
    logic [7:0]  b;
    int          n;
    a = sel ? a_in : (a_in & 16'h00FF);
    b = sel ? b_in : (b_in & 8'h0F);
    e.a = a;
    e.b = b;
    if (b == 8'd0) begin
      e.q = sel ? 16'hFFFF : 16'h00FF;
      e.r = sel ? a[7:0] : {4'h0, a[3:0]};
      e.z = 1'b1;
    end else begin
      e.q = a / 16'(b);
      e.r = 8'(a % 16'(b));
      e.z = 1'b0;
    end
    @(negedge clock);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
    end
    @(posedge clock);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    sb.push_back(e);
  endtask

  task automatic wait_out(output logic ok, output int lat);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    lat = cyc - acc_cyc;
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || quotient_a !== 8'd0 ||
        remainder_a !== 4'd0 || div_zero_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a rdy=%b vld=%b q=%0d r=%0d z=%b required 1 0 0 0 0",
               in_ready_a, out_valid_a, quotient_a, remainder_a, div_zero_a);
    end
    checks++;
    if (in_ready_b !== 1'b1 || out_valid_b !== 1'b0 || quotient_b !== 16'd0 ||
        remainder_b !== 8'd0 || div_zero_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b rdy=%b vld=%b q=%0d r=%0d z=%b required 1 0 0 0 0",
               in_ready_b, out_valid_b, quotient_b, remainder_b, div_zero_b);
    end
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] ta [8] = '{16'd237, 16'd9, 16'd0, 16'd255, 16'd255, 16'd200, 16'd77, 16'd20};
    logic [7:0]  tb [8] = '{8'd10, 8'd10, 8'd10, 8'd1, 8'd15, 8'd7, 8'd0, 8'd3};
    exp_t        e;
    logic        ok;
    int          lat, exp_lat;
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
    sel = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(ta[i], tb[i]);
      wait_out(ok, lat);
      q = quotient; r = remainder; z = div_zero;
      if (ok) handoff();
      e = sb.pop_front();
      exp_lat = (e.b == 8'd0) ? 1 : 8;
      checks++;
      if (!ok || lat != exp_lat) begin
        errors++;
        $display("FAIL dir_latency %0d/%0d ok=%b got %0d required %0d", e.a, e.b, ok, lat, exp_lat);
      end
      checks++;
      if (q !== e.q || r !== e.r) begin
        errors++;
        $display("FAIL dir_result %0d/%0d got q=%0d r=%0d required q=%0d r=%0d", e.a, e.b, q, r, e.q, e.r);
      end
      checks++;
      if (z !== e.z) begin
        errors++;
        $display("FAIL dir_divzero %0d/%0d got %b required %b", e.a, e.b, z, e.z);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    logic ok;
    int   lat;
    logic seen;
    sel = 1'b0;
    send(16'd100, 8'd10);
    wait_out(ok, lat);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_no_result out_valid=%b required 1", out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      dividend = 16'd200;
      divisor  = 8'd3;
      in_valid = 1'b1;
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 16'd10 || remainder !== 8'd0) begin
        errors++;
        $display("FAIL bp_hold vld=%b rdy=%b q=%0d r=%0d required 1 0 10 0",
                 out_valid, in_ready, quotient, remainder);
      end
    end
    in_valid = 1'b0;
    handoff();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release vld=%b rdy=%b required 0 1", out_valid, in_ready);
    end
    e = sb.pop_front();
    checks++;
    if (quotient !== e.q || remainder !== e.r) begin
      errors++;
      $display("FAIL bp_result got q=%0d r=%0d required q=%0d r=%0d", quotient, remainder, e.q, e.r);
    end
    seen = 1'b0;
    repeat (12) begin
      @(negedge clock);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL bp_ignored_input spurious out_valid=%b required 0", seen);
    end
  endtask

  task automatic test_reset_midcalc();
    exp_t e;
    logic ok;
    int   lat;
    logic seen;
    sel = 1'b0;
    send(16'd150, 8'd10);
    repeat (3) @(posedge clock);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 16'd0) begin
      errors++;
      $display("FAIL async_reset rdy=%b vld=%b q=%0d required 1 0 0", in_ready, out_valid, quotient);
    end
    sb.delete();
    @(negedge clock);
    resetn = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clock);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard spurious out_valid=%b required 0", seen);
    end
    send(16'd45, 8'd6);
    wait_out(ok, lat);
    if (ok) handoff();
    e = sb.pop_front();
    checks++;
    if (!ok || quotient !== e.q || remainder !== e.r || lat != 8) begin
      errors++;
      $display("FAIL post_reset_op ok=%b lat=%0d q=%0d r=%0d required 8 q=%0d r=%0d",
               ok, lat, quotient, remainder, e.q, e.r);
    end
  endtask

  task automatic test_random(input logic s, input int n_ops);
    exp_t        e;
    logic        ok;
    int          lat, exp_lat, gap;
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
    sel = s;
    @(negedge clock);
    for (int i = 0; i < n_ops; i++) begin
      gap = $urandom_range(0, 3);
      send(16'($urandom), s ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15)));
      wait_out(ok, lat);
      repeat (gap) @(negedge clock);
      q = quotient; r = remainder; z = div_zero;
      if (ok) handoff();
      e = sb.pop_front();
      exp_lat = (e.b == 8'd0) ? 1 : (s ? 16 : 8);
      checks++;
      if (!ok || lat != exp_lat) begin
        errors++;
        $display("FAIL rnd_latency w%0d %0d/%0d ok=%b got %0d required %0d",
                 s ? 16 : 8, e.a, e.b, ok, lat, exp_lat);
      end
      checks++;
      if (q !== e.q || r !== e.r || z !== e.z) begin
        errors++;
        $display("FAIL rnd_result w%0d %0d/%0d got %0d,%0d,%b required %0d,%0d,%b",
                 s ? 16 : 8, e.a, e.b, q, r, z, e.q, e.r, e.z);
      end
      if (e.b != 8'd0) begin
        checks++;
        if ((32'(q) * 32'(e.b) + 32'(r)) != 32'(e.a) || r >= e.b) begin
          errors++;
          $display("FAIL rnd_identity w%0d %0d/%0d got q=%0d r=%0d", s ? 16 : 8, e.a, e.b, q, r);
        end
      end
    end
  endtask

  initial begin
    resetn    = 1'b0;
    sel       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midcalc();
    test_random(1'b0, 1000);
    test_random(1'b1, 1000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
